vga_frame_monitor: RTL
======================

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning pixels per active line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter CW, default 4, meaning bits per colour channel.
REQ-004 SHALL have parameter SUM_W, default 32, meaning checksum width; 3*CW <= SUM_W.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pix_en  input  1  pixel sample strobe, one clk cycle per pixel period.
REQ-008 SHALL have port rdn  input  1  active-low pixel valid from VGA controller.
REQ-009 SHALL have ports r, g, b  input  CW each  pixel colour.
REQ-010 SHALL have ports hs, vs  input  1 each  horizontal/vertical sync.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when a frame closes.
REQ-012 SHALL have port frame_sum  output  SUM_W  checksum of last closed frame.
REQ-013 SHALL have port pix_count  output  clog2(H_ACTIVE*V_ACTIVE+1)  pixels in last closed frame.
REQ-014 SHALL have port line_count  output  clog2(V_ACTIVE+1)  non-empty lines in last closed frame.
REQ-015 SHALL have ports frame_err, line_err  output  1 each  error flags of last closed frame.
REQ-016 SHALL have port frame_cnt  output  16  number of frames closed since reset, wrapping.

Function
REQ-017 SHALL implement states IDLE and CAPTURE; IDLE -> CAPTURE on first vs rising edge (vs=1, registered vs=0); CAPTURE persists until reset.
REQ-018 SHALL accept a pixel only when state=CAPTURE, pix_en=1, rdn=0; pixels in IDLE ignored.
REQ-019 SHALL update the running checksum per accepted pixel: rotate left by 1, then XOR zero-extended {r,g,b}.
REQ-020 SHALL count accepted pixels per frame and per line; counters saturate at all-ones, never wrap.
REQ-021 SHALL close a line on each hs rising edge in CAPTURE: non-zero line pixel count increments running line count; line pixel count clears.
REQ-022 SHALL, on hs close, set the running line-error bit when line pixel count is non-zero and != H_ACTIVE.
REQ-023 SHALL close a frame on each vs rising edge in CAPTURE: latch checksum, pixel count, line count, line-error into outputs; clear running values.
REQ-024 SHALL set frame_err at close when pixel count != H_ACTIVE*V_ACTIVE or line count != V_ACTIVE.
REQ-025 SHALL assert frame_done in the cycle after the vs edge cycle, for exactly one cycle; increment frame_cnt in that same cycle.
REQ-026 SHALL, when hs and vs edges coincide, close the line first, then include it in the closing frame.
REQ-027 SHALL include a pixel accepted in the vs-edge cycle in the closing frame.
REQ-028 SHALL not close a frame on the IDLE -> CAPTURE transition; no frame_done then.
REQ-029 SHALL hold all outputs except frame_done stable between closes.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, enter IDLE and clear sync registers, running values and all outputs to 0.
REQ-031 SHALL, on reset mid-frame, discard the partial frame; no frame_done.

Configuration
REQ-032 SHALL, with VGA_MON_LINE_ERR_EN defined, implement REQ-022 and drive line_err from it.
REQ-033 SHALL, without VGA_MON_LINE_ERR_EN, omit per-line length check; line_err constant 0; frame_err unaffected.

Verification (H_ACTIVE=4, V_ACTIVE=2, CW=4)
REQ-034 SHALL test: reset, vs edge, 2 lines of 4 pixels {r,g,b}=12'h001, vs edge -> frame_done pulse, frame_sum=0xFF, pix_count=8, line_count=2, errors 0, frame_cnt=1.
REQ-035 SHALL test: second line only 3 pixels -> pix_count=7, frame_err=1, line_err=1 (0 without macro).
REQ-036 SHALL test: pixels with rdn=1 or pix_en=0 interleaved -> ignored; results as REQ-034.
REQ-037 SHALL test: 4th pixel of line 2 in same cycle as coincident hs/vs edges -> pix_count=8, line_count=2, frame_err=0.
REQ-038 SHALL test: rst mid-frame after 5 pixels, then full clean frame -> first close reports REQ-034 values, frame_cnt=1.
REQ-039 SHALL test: pixels before first vs edge -> ignored; no frame_done at first vs edge.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: per-frame checksum, pixel/line counting and geometry checks
// on a VGA pixel stream. Results of each closed frame are latched and held until
// the next close; frame_done pulses one cycle after the closing vs rising edge.
// Ports: clk/rst (sync, active-high); pix_en strobe, rdn active-low pixel valid,
//   r/g/b colour, hs/vs syncs; frame_done, frame_sum, pix_count, line_count,
//   frame_err, line_err, frame_cnt (wrapping count of closed frames).
// Optional feature: define VGA_MON_LINE_ERR_EN to enable the per-line length
//   check that drives line_err; otherwise line_err is tied to 0.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 4,
  parameter int SUM_W    = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     pix_en,
  input  logic                                     rdn,
  input  logic [CW-1:0]                            r,
  input  logic [CW-1:0]                            g,
  input  logic [CW-1:0]                            b,
  input  logic                                     hs,
  input  logic                                     vs,
  output logic                                     frame_done,
  output logic [SUM_W-1:0]                         frame_sum,
  output logic [$clog2(H_ACTIVE*V_ACTIVE+1)-1:0]   pix_count,
  output logic [$clog2(V_ACTIVE+1)-1:0]            line_count,
  output logic                                     frame_err,
  output logic                                     line_err,
  output logic [15:0]                              frame_cnt
);

  localparam int PW  = $clog2(H_ACTIVE*V_ACTIVE+1);
  localparam int LW  = $clog2(V_ACTIVE+1);
  localparam int LPW = $clog2(H_ACTIVE+1);

  localparam logic [PW-1:0] PIX_FULL  = PW'(H_ACTIVE*V_ACTIVE);
  localparam logic [LW-1:0] LINE_FULL = LW'(V_ACTIVE);
`ifdef VGA_MON_LINE_ERR_EN
  localparam logic [LPW-1:0] H_FULL   = LPW'(H_ACTIVE);
`endif

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t state_q, state_d;

  logic             vs_q, hs_q;
  logic             vs_rise, hs_rise;
  logic             accept, line_close, frame_close;

  // Running (in-progress frame) state.
  logic [SUM_W-1:0] sum_q;
  logic [PW-1:0]    pix_q;
  logic [LPW-1:0]   lpix_q;
  logic [LW-1:0]    line_q;

  // "After this cycle" views of the running state: the pixel of this cycle is
  // folded in first, then a line close, so a frame close sees both.
  logic [SUM_W-1:0] sum_a;
  logic [PW-1:0]    pix_a;
  logic [LPW-1:0]   lpix_a;
  logic [LW-1:0]    line_a;
  logic             frame_err_a;

`ifdef VGA_MON_LINE_ERR_EN
  logic             lerr_q;
  logic             lerr_a;
`endif

  assign vs_rise = vs & ~vs_q;
  assign hs_rise = hs & ~hs_q;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && vs_rise) begin
      state_d = CAPTURE;
    end
  end

  always_comb begin
    accept      = (state_q == CAPTURE) && pix_en && !rdn;
    line_close  = (state_q == CAPTURE) && hs_rise;
    frame_close = (state_q == CAPTURE) && vs_rise;

    sum_a  = sum_q;
    pix_a  = pix_q;
    lpix_a = lpix_q;
    line_a = line_q;
`ifdef VGA_MON_LINE_ERR_EN
    lerr_a = lerr_q;
`endif

    if (accept) begin
      sum_a = {sum_q[SUM_W-2:0], sum_q[SUM_W-1]} ^ SUM_W'({r, g, b});
      if (pix_q != '1) begin
        pix_a = pix_q + PW'(1);
      end
      if (lpix_q != '1) begin
        lpix_a = lpix_q + LPW'(1);
      end
    end

    // Empty lines (blanking) are not counted and never flag a length error.
    if (line_close && lpix_a != '0) begin
      if (line_q != '1) begin
        line_a = line_q + LW'(1);
      end
`ifdef VGA_MON_LINE_ERR_EN
      if (lpix_a != H_FULL) begin
        lerr_a = 1'b1;
      end
`endif
    end

    frame_err_a = (pix_a != PIX_FULL) || (line_a != LINE_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      sum_q      <= '0;
      pix_q      <= '0;
      lpix_q     <= '0;
      line_q     <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      pix_count  <= '0;
      line_count <= '0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= '0;
`ifdef VGA_MON_LINE_ERR_EN
      lerr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vs_q       <= vs;
      hs_q       <= hs;
      frame_done <= frame_close;

      if (frame_close) begin
        frame_sum  <= sum_a;
        pix_count  <= pix_a;
        line_count <= line_a;
        frame_err  <= frame_err_a;
        frame_cnt  <= frame_cnt + 16'd1;
        sum_q      <= '0;
        pix_q      <= '0;
        lpix_q     <= '0;
        line_q     <= '0;
`ifdef VGA_MON_LINE_ERR_EN
        line_err   <= lerr_a;
        lerr_q     <= 1'b0;
`else
        line_err   <= 1'b0;
`endif
      end else begin
        sum_q  <= sum_a;
        pix_q  <= pix_a;
        line_q <= line_a;
        lpix_q <= line_close ? '0 : lpix_a;
`ifdef VGA_MON_LINE_ERR_EN
        lerr_q <= lerr_a;
`endif
      end
    end
  end

endmodule
